// File: rtl/data_mem.sv
// data_mem: word-addressed data memory for the core's MEM stage.
// Combinational read, one write per cycle (clear FSM, core store or host
// load), a post-reset clear sequence and a saturating store counter.
module data_mem #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dmem_w_en,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [WIDTH-1:0]  dmem_wdata,
  output logic [WIDTH-1:0]  dmem_rdata,
  input  logic              host_valid,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [WIDTH-1:0]  host_wdata,
  output logic              host_ready,
  output logic              init_done,
  output logic [CNT_W-1:0]  store_count
);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [CNT_W-1:0]  store_count_q, store_count_d;

  // Storage is deliberately left out of reset; the clear FSM zeroes it.
  logic [WIDTH-1:0]  mem_q [DEPTH];

  // Single shared write port: the three writers are mutually exclusive.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  // Next-state, write-port selection and host handshake.
  always_comb begin
    state_d       = state_q;
    clr_idx_d     = clr_idx_q;
    store_count_d = store_count_q;
    wr_en         = 1'b0;
    wr_addr       = clr_idx_q;
    wr_data       = '0;
    host_ready    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        wr_en = 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          // Index is not advanced here: it only returns to 0 via reset.
          state_d = ST_READY;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      ST_READY: begin
        // Core has strict priority; the host waits while the core stores.
        host_ready = !dmem_w_en;
        if (dmem_w_en) begin
          wr_en   = 1'b1;
          wr_addr = dmem_addr;
          wr_data = dmem_wdata;
          if (store_count_q != CNT_MAX) begin
            store_count_d = store_count_q + 1'b1;
          end
        end else if (host_valid) begin
          wr_en   = 1'b1;
          wr_addr = host_addr;
          wr_data = host_wdata;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // State, clear index and store counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_CLEAR;
      clr_idx_q     <= '0;
      store_count_q <= '0;
    end else begin
      state_q       <= state_d;
      clr_idx_q     <= clr_idx_d;
      store_count_q <= store_count_d;
    end
  end

  // Memory array write; anything presented on an edge while reset is high is dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Reads show the pre-edge contents, so a same-cycle write returns old data.
  assign init_done   = (state_q == ST_READY);
  assign dmem_rdata  = init_done ? mem_q[dmem_addr] : '0;
  assign store_count = store_count_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed testbench for data_mem: clear timing, core store/load,
// host arbitration, stores during clear, mid-run reset and saturation.
module tb_data_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmem_w_en;
  logic [5:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        host_valid;
  logic [5:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_ready;
  logic        init_done;
  logic [15:0] store_count;

  logic [31:0] sat_rdata;
  logic        sat_host_ready;
  logic        sat_init_done;
  logic [3:0]  sat_store_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem dut (
    .clk(clk), .reset(reset),
    .dmem_w_en(dmem_w_en), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .host_valid(host_valid), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .init_done(init_done), .store_count(store_count)
  );

  data_mem #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .dmem_w_en(dmem_w_en), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(sat_rdata),
    .host_valid(host_valid), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(sat_host_ready), .init_done(sat_init_done),
    .store_count(sat_store_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    dmem_w_en  = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    host_valid = 1'b0;
    host_addr  = '0;
    host_wdata = '0;

    // ---- 1: reset state, clear timing, all words zero ----
    step(); step();
    check("rst_init_done",  32'(init_done),   32'd0);
    check("rst_host_ready", 32'(host_ready),  32'd0);
    check("rst_count",      32'(store_count), 32'd0);
    check("rst_rdata",      dmem_rdata,       32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      step();
      check($sformatf("t1_init_done_edge%0d", k), 32'(init_done), 32'(k == 64));
    end
    for (int a = 0; a < 64; a++) begin
      dmem_addr = 6'(a);
      #1;
      check($sformatf("t1_zero_addr%0d", a), dmem_rdata, 32'd0);
      step();
    end
    $display("t1 clear sequence: init_done=%0d", init_done);

    // ---- 2: core store/load ----
    dmem_w_en = 1'b1; dmem_addr = 6'd5; dmem_wdata = 32'hDEADBEEF;
    #1;
    check("t2_rdw_old_addr5", dmem_rdata, 32'd0);
    check("t2_host_ready_store", 32'(host_ready), 32'd0);
    step();
    dmem_w_en = 1'b0;
    #1;
    check("t2_read_addr5", dmem_rdata, 32'hDEADBEEF);
    dmem_w_en = 1'b1; dmem_addr = 6'd63; dmem_wdata = 32'h12345678;
    #1;
    check("t2_rdw_old_addr63", dmem_rdata, 32'd0);
    step();
    dmem_w_en = 1'b0;
    #1;
    check("t2_read_addr63", dmem_rdata, 32'h12345678);
    check("t2_count", 32'(store_count), 32'd2);
    $display("t2 store/load: addr63=%h count=%0d", dmem_rdata, store_count);

    // ---- 4: stores and host requests during CLEAR are dropped ----
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      host_valid = (c < 64);
      host_addr  = 6'd3;
      host_wdata = 32'h00000077;
      dmem_w_en  = (c == 10);
      dmem_addr  = 6'd2;
      dmem_wdata = 32'hFFFFFFFF;
      #1;
      check($sformatf("t4_host_ready_c%0d", c), 32'(host_ready), 32'd0);
      if (c == 10) check("t4_rdata_clear", dmem_rdata, 32'd0);
      step();
    end
    dmem_w_en  = 1'b0;
    host_valid = 1'b0;
    #1;
    check("t4_init_done", 32'(init_done), 32'd1);
    check("t4_count", 32'(store_count), 32'd0);
    check("t4_read_addr2", dmem_rdata, 32'd0);
    dmem_addr = 6'd3;
    #1;
    check("t4_read_addr3", dmem_rdata, 32'd0);
    $display("t4 clear-time writes dropped: count=%0d", store_count);

    // ---- 3: host arbitration against core stores ----
    host_valid = 1'b1; host_addr = 6'd10; host_wdata = 32'hA5A5A5A5;
    dmem_w_en  = 1'b1; dmem_addr = 6'd10; dmem_wdata = 32'h11111111;
    for (int c = 1; c <= 3; c++) begin
      #1;
      check($sformatf("t3_host_stalled_c%0d", c), 32'(host_ready), 32'd0);
      step();
    end
    dmem_w_en = 1'b0;
    #1;
    check("t3_host_ready_c4", 32'(host_ready), 32'd1);
    check("t3_core_data", dmem_rdata, 32'h11111111);
    step();
    host_valid = 1'b0;
    #1;
    check("t3_host_data", dmem_rdata, 32'hA5A5A5A5);
    check("t3_count", 32'(store_count), 32'd3);
    $display("t3 arbitration: addr10=%h count=%0d", dmem_rdata, store_count);

    // ---- 5: reset mid-operation ----
    for (int a = 0; a < 4; a++) begin
      dmem_w_en = 1'b1; dmem_addr = 6'(a); dmem_wdata = 32'h100 + 32'(a);
      step();
    end
    dmem_w_en = 1'b0; dmem_addr = 6'd3;
    #1;
    check("t5_prefill_addr3", dmem_rdata, 32'h00000103);
    reset = 1'b1;
    #1;
    check("t5_async_init_done", 32'(init_done),   32'd0);
    check("t5_async_count",     32'(store_count), 32'd0);
    check("t5_async_rdata",     dmem_rdata,       32'd0);
    step();
    reset = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      step();
      check($sformatf("t5_init_done_edge%0d", k), 32'(init_done), 32'(k == 64));
    end
    for (int a = 0; a < 4; a++) begin
      dmem_addr = 6'(a);
      #1;
      check($sformatf("t5_zero_addr%0d", a), dmem_rdata, 32'd0);
    end
    check("t5_count", 32'(store_count), 32'd0);
    $display("t5 mid-run reset: init_done=%0d count=%0d", init_done, store_count);

    // ---- 6: counter saturation (CNT_W=4 instance) ----
    for (int n = 1; n <= 20; n++) begin
      dmem_w_en = 1'b1; dmem_addr = 6'(n); dmem_wdata = 32'(n);
      step();
      check($sformatf("t6_sat_count_n%0d", n), 32'(sat_store_count), (n > 15) ? 32'd15 : 32'(n));
    end
    dmem_w_en = 1'b0;
    step();
    check("t6_sat_hold", 32'(sat_store_count), 32'd15);
    check("t6_wide_count", 32'(store_count), 32'd20);
    $display("t6 saturation: sat_count=%0d wide_count=%0d", sat_store_count, store_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
